serial_cmp_sequencer: RTL and testbench
=======================================

Name: serial_cmp_sequencer

Overview:
- Bit-serial magnitude comparator controller.
- Accepts two N-bit operands through a valid/ready request port.
- Steps one bit per cycle through a single 1-bit compare cell, LSB first. The cell is behavioural and internal to this block: if bits differ, the result is b_bit; if equal, the chained value passes through.
- Returns lt/eq/gt through a valid/ready result port.
- Lets wide operands share one slice instead of an N-deep ripple chain of comparator cells. Chaining inputs allow cascading multiple blocks.

Parameters:
- N, 8, operand width in bits; legal range N >= 2.
- CW, $clog2(N), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  operands valid
- req_ready  out  1  block can accept operands
- a  in  N  operand A
- b  in  N  operand B
- lt_in  in  1  lt from lower-order chunk (0 if unused)
- eq_in  in  1  eq from lower-order chunk (1 if unused)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- lt  out  1  A < B (including chain inputs)
- eq  out  1  A == B and eq_in
- gt  out  1  A > B

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high (rst sampled on rising clk edge).
- Reset values: state=IDLE, req_ready=1, res_valid=0, lt=0, eq=0, gt=0, bit counter=0, shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge E0: capture a, b into shift registers, counter=0, lt_acc=lt_in, eq_acc=eq_in&~lt_in, then go to RUN.
  - lt_in=eq_in=1 is illegal; lt wins and eq is forced 0.
- RUN:
  - req_ready=0.
  - One bit per edge, LSB first: ai=sa[0], bi=sb[0].
  - If ai!=bi: lt_acc=bi, eq_acc=0. Else both are unchanged.
  - Shift sa, sb right; counter+1.
  - The edge processing bit N-1 (edge E0+N) moves to DONE and registers lt=lt_acc', eq=eq_acc', gt=~lt&~eq.
- DONE:
  - res_valid=1; lt/eq/gt held stable until the handshake.
  - On res_valid&&res_ready: go to IDLE, res_valid=0; lt/eq/gt retain their last values.
  - res_ready low: hold indefinitely; no request accepted.
- Latency: res_valid rises N edges after the accept edge. Throughput is one compare per N+2 cycles with res_ready tied high.
- Exactly one of lt/eq/gt is 1 whenever res_valid=1.
- Inputs a, b, lt_in, eq_in are ignored outside the accept edge; changes during RUN have no effect.
- req_valid in RUN/DONE: ignored, not queued.
- res_ready in IDLE/RUN: no effect.
- Reset mid-RUN or mid-DONE: next edge returns to reset values; the in-flight compare is discarded and no res_valid is issued.
- Counter wrap: counter only reaches N-1; there is no wrap in RUN. It is cleared on accept.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. On the MSB step (counter==N-1), if ai!=bi then lt_acc=ai (a negative A is less). All other steps are unchanged.
- Undefined: unsigned compare on every bit, including the MSB.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset, then idle.
  - Stimulus: rst=1 for 2 cycles, release.
  - Response: req_ready=1, res_valid=0, lt=eq=gt=0.
- Basic compare.
  - Stimulus: N=8, a=0x5A, b=0x5B, lt_in=0, eq_in=1; accept at cycle 0.
  - Response: res_valid=1 after edge 8; lt=1, eq=0, gt=0. req_ready=0 through cycles 1-8.
- MSB sign handling.
  - Stimulus: a=0x80, b=0x7F.
  - Response, unsigned build: gt=1.
  - Response, SERIAL_CMP_SIGNED_EN build: lt=1.
  - Response, both builds: a=0xFF vs b=0x01 gives gt=1 unsigned and lt=1 signed.
- Chain inputs.
  - Stimulus: a=b=0x3C with lt_in=1, eq_in=0.
  - Response: lt=1.
  - Stimulus: same operands with lt_in=0, eq_in=1.
  - Response: eq=1.
  - Stimulus: same operands with lt_in=0, eq_in=0.
  - Response: gt=1.
- Backpressure and ignored inputs.
  - Stimulus: res_ready=0 for 5 cycles after res_valid; req_valid held 1 with new operands.
  - Response: lt/eq/gt stable, req_ready=0, no new accept. On res_ready=1, IDLE next cycle; new request accepted the following edge.
  - Stimulus: change a, b mid-RUN.
  - Response: result unaffected.
- Reset mid-operation.
  - Stimulus: assert rst at RUN cycle 4 of a=0x01, b=0x02.
  - Response: next edge gives reset values, with no res_valid pulse.
  - Stimulus: a fresh request after reset.
  - Response: completes correctly, with res_valid 8 edges after its accept.

Source files
------------

// File: rtl/serial_cmp_sequencer.sv
// rtl/serial_cmp_sequencer.sv - bit-serial magnitude comparator with valid/ready request and result ports (optional SERIAL_CMP_SIGNED_EN)
module serial_cmp_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         lt_in,
    input  logic         eq_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          lt_acc;
    logic          eq_acc;
    logic          lt_step;
    logic          eq_step;
    logic          last_bit;
    logic          ai;
    logic          bi;

    assign last_bit = (cnt == LAST);
    assign ai       = sa[0];
    assign bi       = sb[0];

    // One-bit compare cell: a differing bit overrides everything below it
    always_comb begin
        lt_step = lt_acc;
        eq_step = eq_acc;
        if (ai != bi) begin
            eq_step = 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
            // On the sign bit a set A bit means A is negative, hence smaller
            lt_step = last_bit ? ai : bi;
`else
            lt_step = bi;
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        req_ready = (state == IDLE);
        res_valid = (state == DONE);
    end

    // Operand shift registers, bit counter, accumulators and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            lt_acc <= 1'b0;
            eq_acc <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sa     <= a;
                        sb     <= b;
                        cnt    <= '0;
                        lt_acc <= lt_in;
                        // An illegal lt_in=eq_in=1 resolves to lt
                        eq_acc <= eq_in & ~lt_in;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    lt_acc <= lt_step;
                    eq_acc <= eq_step;
                    if (last_bit) begin
                        lt <= lt_step;
                        eq <= eq_step;
                        gt <= ~lt_step & ~eq_step;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmp_sequencer.sv
// tb/tb_serial_cmp_sequencer.sv - self-checking bench for serial_cmp_sequencer
module tb_serial_cmp_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         lt_in = 1'b0;
    logic         eq_in = 1'b1;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         lt;
    logic         eq;
    logic         gt;

    int tests = 0;
    int fails = 0;

    serial_cmp_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .lt_in     (lt_in),
        .eq_in     (eq_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    // Expected {lt,eq,gt} straight from the arithmetic meaning of the compare
    function automatic logic [2:0] ref_cmp(input logic [N-1:0] av, input logic [N-1:0] bv,
                                           input logic li, input logic ei);
        logic less;
        logic more;
`ifdef SERIAL_CMP_SIGNED_EN
        less = ($signed(av) < $signed(bv));
        more = ($signed(av) > $signed(bv));
`else
        less = (av < bv);
        more = (av > bv);
`endif
        if (less) return R_LT;
        if (more) return R_GT;
        if (li) return R_LT;
        if (ei) return R_EQ;
        return R_GT;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy for N edges after an accept, then holds a result
    int         m_left = 0;
    bit         m_done = 1'b0;
    logic [2:0] m_res  = 3'b000;
    logic [2:0] m_pend = 3'b000;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = 3'b000;
        end else if (m_done) begin
            if (res_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else if (req_valid) begin
            m_pend = ref_cmp(a, b, lt_in, eq_in);
            m_left = N;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", int'(req_ready), int'(!m_done && m_left == 0));
            chk("res_valid", int'(res_valid), int'(m_done));
            chk("lt_eq_gt", int'({lt, eq, gt}), int'(m_res));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (!res_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!res_valid) begin
            fails++;
            tests++;
            $display("FAIL drain_timeout: res_valid 0 after %0d cycles, expected 1", w);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run_one(input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic li, input logic ei, input int hold,
                           input bit keep, output logic [2:0] got);
        int w;
        int lat;
        got = 3'b000;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            fails++;
            tests++;
            $display("FAIL req_ready_timeout: req_ready 0 after %0d cycles, expected 1", w);
            return;
        end
        a = av;
        b = bv;
        lt_in = li;
        eq_in = ei;
        req_valid = 1'b1;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        lat = 0;
        // Operands and chain inputs scrambled while the compare is in flight
        while (!res_valid && lat < 40) begin
            a = N'($urandom);
            b = N'($urandom);
            lt_in = 1'($urandom);
            eq_in = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, N);
        got = {lt, eq, gt};
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        if (keep) begin
            // The held request is taken on the edge after the handshake
            chk("idle_after_handshake", int'(req_ready), 1);
            @(negedge clk);
            chk("held_req_accepted", int'(req_ready), 0);
            req_valid = 1'b0;
            drain();
        end
    endtask

    logic [2:0] got;

    initial begin
        do_reset();
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_outputs", int'({lt, eq, gt}), 0);
        chk_en = 1'b1;

        // Pin the reference function with hand-computed values
        chk("model_5a_5b", int'(ref_cmp(8'h5A, 8'h5B, 1'b0, 1'b1)), int'(R_LT));
        chk("model_eq_chain", int'(ref_cmp(8'h3C, 8'h3C, 1'b0, 1'b1)), int'(R_EQ));
        chk("model_illegal_chain", int'(ref_cmp(8'h3C, 8'h3C, 1'b1, 1'b1)), int'(R_LT));

        run_one(8'h5A, 8'h5B, 1'b0, 1'b1, 0, 1'b0, got);
        chk("basic_5a_5b", int'(got), int'(R_LT));

`ifdef SERIAL_CMP_SIGNED_EN
        run_one(8'h80, 8'h7F, 1'b0, 1'b1, 0, 1'b0, got);
        chk("msb_80_7f", int'(got), int'(R_LT));
        run_one(8'hFF, 8'h01, 1'b0, 1'b1, 0, 1'b0, got);
        chk("msb_ff_01", int'(got), int'(R_LT));
`else
        run_one(8'h80, 8'h7F, 1'b0, 1'b1, 0, 1'b0, got);
        chk("msb_80_7f", int'(got), int'(R_GT));
        run_one(8'hFF, 8'h01, 1'b0, 1'b1, 0, 1'b0, got);
        chk("msb_ff_01", int'(got), int'(R_GT));
`endif

        run_one(8'h3C, 8'h3C, 1'b1, 1'b0, 0, 1'b0, got);
        chk("chain_lt", int'(got), int'(R_LT));
        run_one(8'h3C, 8'h3C, 1'b0, 1'b1, 0, 1'b0, got);
        chk("chain_eq", int'(got), int'(R_EQ));
        run_one(8'h3C, 8'h3C, 1'b0, 1'b0, 0, 1'b0, got);
        chk("chain_gt", int'(got), int'(R_GT));

        // Backpressure with a new request held pending the whole time
        run_one(8'h10, 8'h20, 1'b0, 1'b1, 5, 1'b1, got);
        chk("backpressure_result", int'(got), int'(R_LT));

        // Reset in the middle of a compare
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        lt_in = 1'b0;
        eq_in = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_reset_req_ready", int'(req_ready), 1);
        chk("midrun_reset_res_valid", int'(res_valid), 0);
        chk("midrun_reset_outputs", int'({lt, eq, gt}), 0);
        repeat (12) @(negedge clk);
        chk("no_stale_res_valid", int'(res_valid), 0);
        run_one(8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b0, got);
        chk("after_reset", int'(got), int'(R_LT));

        // Randomized compares, including equal operands and illegal chain inputs
        for (int i = 0; i < 80; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            logic         rli;
            logic         rei;
            ra  = N'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
            rli = 1'($urandom);
            rei = 1'($urandom);
            run_one(ra, rb, rli, rei, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0), got);
            chk("random_result", int'(got), int'(ref_cmp(ra, rb, rli, rei)));
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
